mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 16 +
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: controller states and
// the default data width and memory depth.
package mem_access_pkg;

   // Controller states; IDLE is the only state that accepts a request
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int DATA_W_DEF    = 32;
   localparam int MEM_DEPTH_DEF = 100;

endpackage : mem_access_pkg

// File: rtl/mem_access_unit.sv
// Memory access unit: takes one word read or write request at a time over
// a valid/ready request port, runs it against a word memory and returns a
// response over a valid/ready response port.
// Optional address range checking is compiled in with the macro
// MEM_ACCESS_BOUNDS_CHECK_EN; out-of-range requests then get an error
// response without ever touching the memory.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out
);

   localparam logic [DATA_W-1:0] DEPTH_LIMIT = DATA_W'(MEM_DEPTH);

   state_t            r_state;
   state_t            w_nextState;
   logic [DATA_W-1:0] r_memAddress;
   logic [DATA_W-1:0] r_memDataIn;
   logic [DATA_W-1:0] r_respRdata;
   logic              w_accept;
   logic              w_outOfRange;

   assign w_accept = req_valid && (r_state == IDLE);

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
   assign w_outOfRange = (req_addr >= DEPTH_LIMIT);
`else
   logic w_unusedDepthCmp;
   assign w_unusedDepthCmp = (req_addr >= DEPTH_LIMIT);
   assign w_outOfRange     = 1'b0;
`endif

   // State register; reset abandons whatever transaction is in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state selection and the state-decoded handshake/strobe outputs
   always_comb begin
      w_nextState = r_state;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      mem_wr      = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_outOfRange) begin
                  w_nextState = RESP;
               end else if (req_we) begin
                  w_nextState = WRITE;
               end else begin
                  w_nextState = READ;
               end
            end
         end
         WRITE: begin
            mem_wr      = ~reset;
            w_nextState = RESP;
         end
         READ: begin
            w_nextState = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Request latch and response data capture; the memory address and write
   // data hold their last accepted values between transactions
   always_ff @(posedge clk) begin
      if (reset) begin
         r_memAddress <= '0;
         r_memDataIn  <= '0;
         r_respRdata  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_outOfRange) begin
                     r_respRdata <= '0;
                  end else begin
                     r_memAddress <= req_addr;
                     r_memDataIn  <= req_wdata;
                  end
               end
            end
            WRITE: begin
               r_respRdata <= '0;
            end
            READ: begin
               r_respRdata <= mem_data_out;
            end
            default: begin
               r_respRdata <= r_respRdata;
            end
         endcase
      end
   end

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
   logic r_respErr;

   // Error flag: raised when an out-of-range request is accepted, dropped
   // when its response is taken
   always_ff @(posedge clk) begin
      if (reset) begin
         r_respErr <= 1'b0;
      end else if (w_accept && w_outOfRange) begin
         r_respErr <= 1'b1;
      end else if ((r_state == RESP) && resp_ready) begin
         r_respErr <= 1'b0;
      end
   end

   assign resp_err = r_respErr;
`else
   assign resp_err = 1'b0;
`endif

   assign mem_address = r_memAddress;
   assign mem_data_in = r_memDataIn;
   assign resp_rdata  = r_respRdata;

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: pairs the unit with a word memory model
// and checks directed and random transactions against a transaction-level
// reference memory. Expectations follow MEM_ACCESS_BOUNDS_CHECK_EN when it
// is defined for the build.
module tb_mem_access_unit;

   localparam int DATA_W    = 32;
   localparam int MEM_DEPTH = 100;
   localparam int MEM_WORDS = 128;

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   logic              clk;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [DATA_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;

   logic [DATA_W-1:0] memArray [0:MEM_WORDS-1];
   logic [DATA_W-1:0] refMem   [0:MEM_WORDS-1];

   int vectorCount = 0;
   int missCount   = 0;

   mem_access_unit #(
      .DATA_W    (DATA_W),
      .MEM_DEPTH (MEM_DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_wr       (mem_wr),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [DATA_W-1:0] initWord(input int idx);
      return 32'h1000_0000 + 32'(idx) * 32'h0001_0101;
   endfunction

   // Word memory contents at power-up
   initial begin
      for (int i = 0; i < MEM_WORDS; i++) begin
         memArray[i] = initWord(i);
      end
      mem_data_out = '0;
   end

   // Word memory: writes on the rising edge, read data refreshed on the
   // falling edge while no write is strobed
   always @(posedge clk) begin
      if (mem_wr) begin
         memArray[mem_address[6:0]] <= mem_data_in;
      end
   end

   always @(negedge clk) begin
      if (!mem_wr) begin
         mem_data_out <= memArray[mem_address[6:0]];
      end
   end

   // Guard against a hung run
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                              input logic [DATA_W-1:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // One complete transaction; hold is the number of extra cycles the
   // response is left waiting with resp_ready low
   task automatic applyStimulus(input logic we, input logic [DATA_W-1:0] addr,
                                input logic [DATA_W-1:0] wdata, input int hold);
      logic              oor;
      logic [DATA_W-1:0] expData;
      int                waited;
      oor     = BOUNDS_EN && (addr >= DATA_W'(MEM_DEPTH));
      expData = (we || oor) ? '0 : refMem[addr[6:0]];
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_addr   = addr;
      req_wdata  = wdata;
      resp_ready = (hold == 0);
      waited     = 0;
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("accept_wait", 32'(waited < 20), 32'd1);
      if (waited >= 20) begin
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      if (we && !oor) begin
         refMem[addr[6:0]] = wdata;
      end
      @(negedge clk);
      checkOutput("c1_resp_valid", 32'(resp_valid), 32'(oor));
      checkOutput("c1_mem_wr", 32'(mem_wr), 32'(we && !oor));
      if (!oor) begin
         checkOutput("c1_mem_address", mem_address, addr);
         if (we) begin
            checkOutput("c1_mem_data_in", mem_data_in, wdata);
         end
         @(negedge clk);
         checkOutput("c2_resp_valid", 32'(resp_valid), 32'd1);
         checkOutput("c2_mem_wr", 32'(mem_wr), 32'd0);
      end
      checkOutput("resp_rdata", resp_rdata, expData);
      checkOutput("resp_err", 32'(resp_err), 32'(oor));
      checkOutput("busy_req_ready", 32'(req_ready), 32'd0);
      for (int j = 1; j <= hold; j++) begin
         @(negedge clk);
         checkOutput("hold_resp_valid", 32'(resp_valid), 32'd1);
         checkOutput("hold_resp_rdata", resp_rdata, expData);
         checkOutput("hold_resp_err", 32'(resp_err), 32'(oor));
         checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
         if (j == hold) begin
            resp_ready = 1'b1;
         end
      end
      @(negedge clk);
      checkOutput("done_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("done_resp_err", 32'(resp_err), 32'd0);
      checkOutput("done_req_ready", 32'(req_ready), 32'd1);
   endtask

   // Reads of addresses 0..3 with req_valid held high; acceptances must be
   // three cycles apart and data must come back in order
   task automatic applyBackToBack();
      int cyc;
      int accepted;
      int lastAcc;
      int got;
      cyc      = 0;
      accepted = 0;
      lastAcc  = 0;
      got      = 0;
      @(negedge clk);
      resp_ready = 1'b1;
      req_we     = 1'b0;
      req_wdata  = '0;
      req_addr   = '0;
      req_valid  = 1'b1;
      while (got < 4 && cyc < 60) begin
         if (resp_valid) begin
            checkOutput("b2b_rdata", resp_rdata, refMem[got]);
            got++;
         end
         if (req_ready) begin
            if (accepted < 4) begin
               if (accepted > 0) begin
                  checkOutput("b2b_spacing", 32'(cyc - lastAcc), 32'd3);
               end
               lastAcc   = cyc;
               req_addr  = 32'(accepted);
               req_valid = 1'b1;
               accepted++;
            end else begin
               req_valid = 1'b0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      req_valid = 1'b0;
      checkOutput("b2b_count", 32'(got), 32'd4);
      @(negedge clk);
   endtask

   // Reset landing in the WRITE cycle must kill the write and its response
   task automatic applyResetInWrite();
      int waited;
      @(negedge clk);
      resp_ready = 1'b1;
      req_we     = 1'b1;
      req_addr   = 32'd7;
      req_wdata  = 32'h0000_1234;
      req_valid  = 1'b1;
      waited     = 0;
      while (!req_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("rst_accept_wait", 32'(waited < 20), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checkOutput("rst_mem_wr_before", 32'(mem_wr), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("rst_mem_wr_suppressed", 32'(mem_wr), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
      checkOutput("rst_mem_address", mem_address, 32'd0);
      checkOutput("rst_mem_data_in", mem_data_in, 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("rst_no_response", 32'(resp_valid), 32'd0);
      end
   endtask

   // Test sequence
   initial begin
      logic              rWe;
      logic [DATA_W-1:0] rAddr;
      for (int i = 0; i < MEM_WORDS; i++) begin
         refMem[i] = initWord(i);
      end
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("reset_resp_rdata", resp_rdata, 32'd0);
      checkOutput("reset_resp_err", 32'(resp_err), 32'd0);
      checkOutput("reset_mem_address", mem_address, 32'd0);
      checkOutput("reset_mem_data_in", mem_data_in, 32'd0);
      checkOutput("reset_mem_wr", 32'(mem_wr), 32'd0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle_req_ready", 32'(req_ready), 32'd1);

      $display("[TB] write/read address 5");
      applyStimulus(1'b1, 32'd5, 32'hDEAD_BEEF, 0);
      applyStimulus(1'b0, 32'd5, 32'h0, 0);

      $display("[TB] stalled response");
      applyStimulus(1'b0, 32'd5, 32'h0, 4);

      $display("[TB] back-to-back reads");
      applyBackToBack();

      $display("[TB] reset during write");
      applyResetInWrite();
      applyStimulus(1'b0, 32'd7, 32'h0, 0);

      $display("[TB] address 100");
      applyStimulus(1'b1, 32'd100, 32'hCAFE_F00D, 0);
      applyStimulus(1'b0, 32'd100, 32'h0, 1);
      applyStimulus(1'b0, 32'd99, 32'h0, 0);

      $display("[TB] random transactions");
      for (int n = 0; n < 60; n++) begin
         rWe   = 1'($urandom_range(0, 1));
         rAddr = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15))
                                             : 32'($urandom_range(0, 119));
         applyStimulus(rWe, rAddr, $urandom, int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule : tb_mem_access_unit
